// File: rtl/ntt_core.sv
// Forward negacyclic NTT for Z_q[x]/(x^256+1), in place on an external
// single-port RAM. The core runs three phases. First it pre-scales each a[k]
// by psi^k. Then it bit-reverses the array. Then it runs eight Cooley-Tukey
// stages, so the output is in natural order.
module ntt_core #(
  parameter int WIDTH       = 24,
  parameter int Q           = 8380417,
  parameter int MU          = 33587228,
  parameter int PSI         = 1753,
  parameter int MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       dbg_stage,
  output logic             dbg_butterfly_done
);

  localparam int PW = 2 * WIDTH;   // product width
  localparam int TW = PW + 26;     // product * MU width
  localparam int RW = PW + 2;      // Barrett remainder width

  typedef enum logic [4:0] {
    S_IDLE, S_PRE_READ, S_PRE_WAIT, S_PRE_MUL, S_PRE_CALC_WAIT, S_PRE_WRITE, S_PRE_NEXT,
    S_BR_CHECK, S_BR_READ_A, S_BR_READ_B, S_BR_WAIT, S_BR_LATCH_B, S_BR_WRITE_A, S_BR_WRITE_B,
    S_STAGE_INIT, S_BLK_INIT, S_BF_READ_U, S_BF_READ_V, S_BF_WAIT_U, S_BF_MUL, S_BF_CALC_WAIT,
    S_WRITE_U, S_WRITE_V, S_BF_NEXT, S_DONE
  } state_t;

  // Estimate the quotient as floor(x*MU/2^48). The estimate is short by at most 2.
  function automatic logic [WIDTH-1:0] barrett(input logic [PW-1:0] x);
    logic [TW-1:0] t;
    logic [RW-1:0] r;
    t = TW'(x) * TW'(MU);
    r = RW'(x) - RW'(t >> PW) * RW'(Q);
    if (r >= RW'(Q)) r = r - RW'(Q);
    if (r >= RW'(Q)) r = r - RW'(Q);
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (WIDTH+1)'(Q)) s = s - (WIDTH+1)'(Q);
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : ((WIDTH'(Q) - b) + a);
  endfunction

  // Evaluated at elaboration time to fill the stage-root ROM.
  function automatic logic [WIDTH-1:0] psi_pow(input int e);
    logic [63:0] acc;
    acc = 64'd1;
    for (int k = 0; k < e; k++) acc = (acc * 64'(PSI)) % 64'(Q);
    return acc[WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  logic [8:0] cnt_q, cnt_d, i_q, i_d, j_q, j_d, mid_q, mid_d;
  logic [3:0] stage_q, stage_d;
  logic [2:0] wait_q, wait_d;
  logic [WIDTH-1:0] factor_q, factor_d, gk_q, gk_d, gkn_q, gkn_d, w_q, w_d;
  logic [WIDTH-1:0] u_q, u_d, res_q, res_d;
  logic [WIDTH-1:0] mula_x_q, mula_x_d, mula_y_q, mula_y_d, mulb_x_q, mulb_x_d, mulb_y_q, mulb_y_d;
  logic [PW-1:0]    prod_a_q, prod_b_q;
  logic [WIDTH-1:0] red_a_q, red_b_q;
  logic [7:0]       addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]       rev_idx;
  logic [8:0]       idx_u, idx_v, i_step;
  logic [WIDTH-1:0] g1_ntt_rom [8];

  // Stage root for half-size mid = 2^s is psi^(256/mid).
  for (genvar gi = 0; gi < 8; gi++) begin : g_rom
    localparam logic [WIDTH-1:0] ROOT = psi_pow(256 >> gi);
    assign g1_ntt_rom[gi] = ROOT;
  end

  // Bit reversal of the 8-bit pre-scale/swap index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign rev_idx[gi] = cnt_q[7-gi];
  end

  assign idx_u  = i_q + j_q;
  assign idx_v  = idx_u + mid_q;
  assign i_step = i_q + (mid_q << 1);

  assign done               = (state_q == S_DONE);
  assign dbg_butterfly_done = (state_q == S_WRITE_V);
  assign dbg_stage          = stage_q;
  assign mem_addr           = addr_q;
  assign mem_we             = we_q;
  assign mem_wdata          = wdata_q;

  // Two free-running multiplier lanes: operand regs -> product reg -> reduced reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_a_q <= '0; prod_b_q <= '0; red_a_q <= '0; red_b_q <= '0;
    end else begin
      prod_a_q <= PW'(mula_x_q) * PW'(mula_y_q);
      prod_b_q <= PW'(mulb_x_q) * PW'(mulb_y_q);
      red_a_q  <= barrett(prod_a_q);
      red_b_q  <= barrett(prod_b_q);
    end
  end

  // Control state, counters, datapath registers and registered RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; cnt_q <= '0; i_q <= '0; j_q <= '0; mid_q <= 9'd1; stage_q <= '0;
      wait_q <= '0; factor_q <= WIDTH'(1); gk_q <= WIDTH'(1); gkn_q <= '0; w_q <= '0;
      u_q <= '0; res_q <= '0; mula_x_q <= '0; mula_y_q <= '0; mulb_x_q <= '0; mulb_y_q <= '0;
      addr_q <= '0; we_q <= 1'b0; wdata_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; i_q <= i_d; j_q <= j_d; mid_q <= mid_d; stage_q <= stage_d;
      wait_q <= wait_d; factor_q <= factor_d; gk_q <= gk_d; gkn_q <= gkn_d; w_q <= w_d;
      u_q <= u_d; res_q <= res_d; mula_x_q <= mula_x_d; mula_y_q <= mula_y_d;
      mulb_x_q <= mulb_x_d; mulb_y_q <= mulb_y_d;
      addr_q <= addr_d; we_q <= we_d; wdata_q <= wdata_d;
    end
  end

  // Next-state logic: everything holds by default, write enable defaults low.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; i_d = i_q; j_d = j_q; mid_d = mid_q; stage_d = stage_q;
    wait_d = wait_q; factor_d = factor_q; gk_d = gk_q; gkn_d = gkn_q; w_d = w_q;
    u_d = u_q; res_d = res_q; mula_x_d = mula_x_q; mula_y_d = mula_y_q;
    mulb_x_d = mulb_x_q; mulb_y_d = mulb_y_q;
    addr_d = addr_q; we_d = 1'b0; wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        cnt_d = '0; factor_d = WIDTH'(1); mid_d = 9'd1; stage_d = '0; state_d = S_PRE_READ;
      end
      S_PRE_READ: begin addr_d = cnt_q[7:0]; state_d = S_PRE_WAIT; end
      S_PRE_WAIT: state_d = S_PRE_MUL;
      S_PRE_MUL: begin
        mula_x_d = mem_rdata; mula_y_d = factor_q; mulb_x_d = factor_q; mulb_y_d = WIDTH'(PSI);
        wait_d = 3'(MUL_LATENCY); state_d = S_PRE_CALC_WAIT;
      end
      S_PRE_CALC_WAIT: if (wait_q == 3'd0) begin
        res_d = red_a_q; factor_d = red_b_q; state_d = S_PRE_WRITE;
      end else wait_d = wait_q - 3'd1;
      S_PRE_WRITE: begin we_d = 1'b1; addr_d = cnt_q[7:0]; wdata_d = res_q; state_d = S_PRE_NEXT; end
      S_PRE_NEXT: if (cnt_q[7:0] == 8'hFF) begin cnt_d = '0; state_d = S_BR_CHECK; end
                  else begin cnt_d = cnt_q + 9'd1; state_d = S_PRE_READ; end
      // Only the lower index of each pair performs the swap.
      S_BR_CHECK: if (cnt_q[8]) begin mid_d = 9'd1; stage_d = '0; state_d = S_STAGE_INIT; end
                  else if (cnt_q[7:0] < rev_idx) state_d = S_BR_READ_A;
                  else cnt_d = cnt_q + 9'd1;
      S_BR_READ_A:  begin addr_d = cnt_q[7:0]; state_d = S_BR_READ_B; end
      S_BR_READ_B:  begin addr_d = rev_idx; state_d = S_BR_WAIT; end
      S_BR_WAIT:    begin u_d = mem_rdata; state_d = S_BR_LATCH_B; end
      S_BR_LATCH_B: begin res_d = mem_rdata; state_d = S_BR_WRITE_A; end
      S_BR_WRITE_A: begin we_d = 1'b1; addr_d = cnt_q[7:0]; wdata_d = res_q; state_d = S_BR_WRITE_B; end
      S_BR_WRITE_B: begin
        we_d = 1'b1; addr_d = rev_idx; wdata_d = u_q; cnt_d = cnt_q + 9'd1; state_d = S_BR_CHECK;
      end
      S_STAGE_INIT: if (mid_q[8]) state_d = S_DONE;
                    else begin w_d = g1_ntt_rom[stage_q[2:0]]; i_d = '0; state_d = S_BLK_INIT; end
      S_BLK_INIT:  begin gk_d = WIDTH'(1); j_d = '0; state_d = S_BF_READ_U; end
      // u and v reads are issued back to back; each lands two edges later.
      S_BF_READ_U: begin addr_d = idx_u[7:0]; state_d = S_BF_READ_V; end
      S_BF_READ_V: begin addr_d = idx_v[7:0]; state_d = S_BF_WAIT_U; end
      S_BF_WAIT_U: begin u_d = mem_rdata; state_d = S_BF_MUL; end
      S_BF_MUL: begin
        mula_x_d = mem_rdata; mula_y_d = gk_q; mulb_x_d = gk_q; mulb_y_d = w_q;
        wait_d = 3'(MUL_LATENCY); state_d = S_BF_CALC_WAIT;
      end
      S_BF_CALC_WAIT: if (wait_q == 3'd0) begin
        res_d = red_a_q; gkn_d = red_b_q; state_d = S_WRITE_U;
      end else wait_d = wait_q - 3'd1;
      S_WRITE_U: begin we_d = 1'b1; addr_d = idx_u[7:0]; wdata_d = mod_add(u_q, res_q); state_d = S_WRITE_V; end
      S_WRITE_V: begin we_d = 1'b1; addr_d = idx_v[7:0]; wdata_d = mod_sub(u_q, res_q); state_d = S_BF_NEXT; end
      S_BF_NEXT: begin
        gk_d = gkn_q;
        if (j_q + 9'd1 == mid_q) begin
          j_d = '0;
          if (i_step[8]) begin mid_d = mid_q << 1; stage_d = stage_q + 4'd1; state_d = S_STAGE_INIT; end
          else begin i_d = i_step; state_d = S_BLK_INIT; end
        end else begin
          j_d = j_q + 9'd1; state_d = S_BF_READ_U;
        end
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ntt_core.sv
// Directed bench for ntt_core: RAM model, direct-sum golden NTT, scenario tasks.
module tb_ntt_core;
  localparam int WIDTH = 24;
  localparam int Q     = 8380417;
  localparam int PSI   = 1753;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             done;
  logic [7:0]       mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [3:0]       dbg_stage;
  logic             dbg_butterfly_done;

  logic [WIDTH-1:0] ram [256];
  logic [WIDTH-1:0] load_buf [256];
  logic             load_req = 1'b0;
  logic [WIDTH-1:0] rdata_q;

  longint unsigned  pw [512];
  logic [WIDTH-1:0] gold [256];

  int checks = 0;
  int errors = 0;
  int run_bf, run_cycles;
  bit run_timeout;

  always #5 clk = ~clk;

  ntt_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_stage(dbg_stage), .dbg_butterfly_done(dbg_butterfly_done)
  );

  // Synchronous RAM with one wait state; bulk load port for the bench.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 256; k++) ram[k] <= load_buf[k];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rdata_q <= ram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  task automatic load_ram();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  // A[k] = sum_j a[j] * psi^(j*(2k+1)) mod Q, straight from the definition.
  task automatic compute_golden();
    longint unsigned acc;
    for (int k = 0; k < 256; k++) begin
      acc = 0;
      for (int j = 0; j < 256; j++)
        if (load_buf[j] != '0)
          acc = (acc + longint'(load_buf[j]) * pw[(j * (2 * k + 1)) % 512]) % longint'(Q);
      gold[k] = WIDTH'(acc);
    end
  endtask

  task automatic run_ntt(input bit hold);
    run_bf = 0; run_cycles = 0; run_timeout = 1'b1;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (!hold && c == 0) start = 1'b0;
      if (c == 1000) start = 1'b1;          // stray pulse mid-run must be ignored
      if (!hold && c == 1001) start = 1'b0;
      if (dbg_butterfly_done) run_bf++;
      if (done) begin run_timeout = 1'b0; run_cycles = c; break; end
    end
    $display("run hold=%0d cycles=%0d butterflies=%0d timeout=%0d", hold, run_cycles, run_bf, run_timeout);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", mem_addr); end
    checks++; if (mem_wdata !== 24'd0) begin errors++; $display("FAIL reset_wdata got %0d expected 0", mem_wdata); end
    checks++; if (dbg_stage !== 4'd0) begin errors++; $display("FAIL reset_stage got %0d expected 0", dbg_stage); end
    checks++; if (dbg_butterfly_done !== 1'b0) begin errors++; $display("FAIL reset_bfdone got %b expected 0", dbg_butterfly_done); end
    rst_n = 1'b1;
    $display("reset test complete");
  endtask

  task automatic test_delta();
    for (int k = 0; k < 256; k++) load_buf[k] = '0;
    load_buf[0] = 24'd1;
    load_ram();
    run_ntt(1'b0);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL delta_timeout got %0d expected 0", run_timeout); end
    checks++; if (run_bf !== 1024) begin errors++; $display("FAIL delta_bf_count got %0d expected 1024", run_bf); end
    checks++; if (dbg_stage !== 4'd8) begin errors++; $display("FAIL delta_stage got %0d expected 8", dbg_stage); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (ram[k] !== 24'd1) begin errors++; $display("FAIL delta A[%0d] got %0d expected 1", k, ram[k]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL delta_done_drop got %b expected 0", done); end
  endtask

  task automatic test_single();
    for (int k = 0; k < 256; k++) load_buf[k] = '0;
    load_buf[1] = 24'd1;
    load_ram();
    compute_golden();
    run_ntt(1'b0);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got %0d expected 0", run_timeout); end
    checks++; if (ram[0] !== 24'd1753) begin errors++; $display("FAIL single A[0] got %0d expected 1753", ram[0]); end
    checks++; if (ram[1] !== 24'd6757063) begin errors++; $display("FAIL single A[1] got %0d expected 6757063", ram[1]); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (ram[k] !== gold[k]) begin errors++; $display("FAIL single A[%0d] got %0d expected %0d", k, ram[k], gold[k]); end
    end
  endtask

  task automatic test_abort_rerun();
    bit reached;
    for (int k = 0; k < 256; k++) load_buf[k] = WIDTH'($urandom_range(0, Q - 1));
    load_buf[0] = WIDTH'(Q - 1); load_buf[255] = WIDTH'(Q - 1); load_buf[128] = '0;
    load_ram();
    compute_golden();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (dbg_stage == 4'd3) begin reached = 1'b1; break; end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL abort_reach_stage3 got %0d expected 1", reached); end
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b expected 0", done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b expected 0", mem_we); end
    checks++; if (dbg_stage !== 4'd0) begin errors++; $display("FAIL abort_stage got %0d expected 0", dbg_stage); end
    @(negedge clk); rst_n = 1'b1;
    $display("abort during stage 3 applied");
    load_ram();
    run_ntt(1'b1);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL rerun_timeout got %0d expected 0", run_timeout); end
    checks++; if (run_bf !== 1024) begin errors++; $display("FAIL rerun_bf_count got %0d expected 1024", run_bf); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (ram[k] !== gold[k]) begin errors++; $display("FAIL rerun A[%0d] got %0d expected %0d", k, ram[k], gold[k]); end
    end
  endtask

  // Entered with start still held high and the core in DONE.
  task automatic test_hold_done();
    int low_cnt, wr_cnt;
    low_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b1) low_cnt++;
      if (mem_we !== 1'b0) wr_cnt++;
    end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL hold_done_low_cycles got %0d expected 0", low_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL hold_write_cycles got %0d expected 0", wr_cnt); end
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_release_done got %b expected 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b expected 0", mem_we); end
    $display("hold-after-done test complete");
  endtask

  initial begin
    pw[0] = 1;
    for (int e = 1; e < 512; e++) pw[e] = (pw[e - 1] * longint'(PSI)) % longint'(Q);
    test_reset();
    test_delta();
    test_single();
    test_abort_rerun();
    test_hold_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
